reg_dump: RTL and testbench
===========================

REG_DUMP -- requirements
Module: reg_dump

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NUM_REG, 32, number of registers in the register file being read
- REG_ADDR_WIDTH, 5, register address width
- REG_WIDTH, 32, register data width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a dump; sampled only in IDLE
- start_addr  in  REG_ADDR_WIDTH  first register to read; sampled with start
- end_addr  in  REG_ADDR_WIDTH  last register to read; sampled with start
- rd_addr  out  REG_ADDR_WIDTH  read address to the register file's combinational read port
- rd_data  in  REG_WIDTH  register file read data, valid in the same cycle as rd_addr
- out_valid  out  1  out_data, out_addr and out_last are valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- out_data  out  REG_WIDTH  captured register value
- out_addr  out  REG_ADDR_WIDTH  register index of out_data
- out_last  out  1  current word is the final word of the dump
- abort  in  1  terminate the dump immediately
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last word is accepted
REQ-003 Clock and reset SHALL be clk and rst, one clock domain, with reset synchronous and active-high.

Function
REQ-004 The FSM SHALL have the states IDLE, READ, SEND and DONE.
REQ-005 In IDLE, start=1 SHALL latch start_addr into cur and end_addr into last, then go to READ.
REQ-006 In READ, rd_addr SHALL equal cur; at the clock edge, out_data<=rd_data, out_addr<=cur, out_last<=(cur==last), out_valid<=1, then go to SEND.
REQ-007 In SEND, out_data, out_addr and out_last SHALL hold stable while out_valid && !out_ready.
REQ-008 In SEND, a handshake SHALL clear out_valid at the next edge.
  - If out_last=1, the next state SHALL be DONE.
  - Otherwise cur SHALL advance to (cur+1) mod NUM_REG and the next state SHALL be READ.
REQ-009 Throughput SHALL be one word per two cycles when out_ready is held high.
  - Latency from start to the first out_valid SHALL be 2 cycles.
REQ-010 Wrap-around: if end_addr < start_addr, the dump SHALL run start_addr..NUM_REG-1, then 0..end_addr.
  - Word count = ((end_addr-start_addr) mod NUM_REG)+1.
REQ-011 If start_addr==end_addr, exactly one word SHALL be emitted, with out_last=1.
REQ-012 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; done=0 in all other states.
REQ-013 start SHALL be ignored in READ, SEND and DONE; a new dump needs a start in IDLE.
REQ-014 abort=1 in any non-IDLE state SHALL force IDLE at the next edge.
  - out_valid<=0 and done stays 0.
  - abort SHALL take priority over a simultaneous handshake.
  - abort in IDLE SHALL have no effect, and SHALL take priority over a simultaneous start.
REQ-015 rd_addr SHALL equal cur in every state; the block SHALL never write the register file.
REQ-016 Coherence of values across a dump is not guaranteed.
  - Each word SHALL reflect rd_data at its own READ cycle.
REQ-017 busy SHALL be 1 exactly when state != IDLE.

Reset
REQ-018 rst=1 at a clock edge SHALL force IDLE regardless of the current state, including mid-dump.
  - All of these SHALL be 0: out_valid, out_data, out_addr, out_last, done, busy, cur, last, rd_addr.
REQ-019 rst SHALL take priority over abort, start and handshakes.

Verification
REQ-020 start_addr=1, end_addr=5, register file preloaded 0..5 with value=index, out_ready=1 -> five words: addr/data 1/1, 2/2, 3/3, 4/4, 5/5.
  - out_last only on addr 5; done pulses 1 cycle after that handshake.
REQ-021 start_addr=30, end_addr=1 -> four words with out_addr 30, 31, 0, 1; out_last on addr 1.
REQ-022 start_addr=end_addr=7, out_ready low for 3 cycles -> one word, out_addr=7, out_last=1.
  - out_data held stable for all 3 stalled cycles; done after the handshake.
REQ-023 Dump 0..31 with abort pulsed after the 3rd handshake -> out_valid=0 and IDLE next cycle.
  - done never asserts; a new start then runs normally.
REQ-024 rst=1 while in SEND with out_valid=1 -> next cycle all outputs 0 and busy=0.
  - start held high during the busy dump -> no restart until done returns the FSM to IDLE.

Source files
------------

// File: rtl/reg_dump_if.sv
// Output word stream of reg_dump: valid/ready handshake carrying one
// captured register value with its index and an end-of-dump marker.
//   out_valid : word on out_data/out_addr/out_last is valid
//   out_ready : consumer accepts the word when out_valid && out_ready
//   out_data  : captured register value
//   out_addr  : register index of out_data
//   out_last  : current word is the final word of the dump
interface reg_dump_if #(
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned REG_WIDTH      = 32
);
   logic                      out_valid;
   logic                      out_ready;
   logic [REG_WIDTH-1:0]      out_data;
   logic [REG_ADDR_WIDTH-1:0] out_addr;
   logic                      out_last;

   // Producer side (reg_dump)
   modport master (
      output out_valid,
      output out_data,
      output out_addr,
      output out_last,
      input  out_ready
   );

   // Consumer side
   modport slave (
      input  out_valid,
      input  out_data,
      input  out_addr,
      input  out_last,
      output out_ready
   );
endinterface

// File: rtl/reg_dump.sv
// Register-file dumper: walks a (possibly wrapping) address range of a
// register file through its combinational read port and streams every
// value out over a valid/ready interface, one word per two cycles.
// Ports:
//   clk, rst             : single clock, synchronous active-high reset
//   start                : request a dump (sampled only when idle)
//   start_addr, end_addr : first / last register of the dump (sampled with start)
//   rd_addr, rd_data     : register file read port (data valid same cycle)
//   abort                : terminate a running dump at the next edge
//   busy                 : dump in progress (any state but IDLE)
//   done                 : one-cycle pulse after the final word is accepted
//   stream               : output word stream (reg_dump_if master)
module reg_dump #(
   parameter int unsigned NUM_REG        = 32,
   parameter int unsigned REG_ADDR_WIDTH = 5,
   parameter int unsigned REG_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [REG_ADDR_WIDTH-1:0] start_addr,
   input  logic [REG_ADDR_WIDTH-1:0] end_addr,
   output logic [REG_ADDR_WIDTH-1:0] rd_addr,
   input  logic [REG_WIDTH-1:0]      rd_data,
   input  logic                      abort,
   output logic                      busy,
   output logic                      done,
   reg_dump_if.master                stream
);

   localparam logic [REG_ADDR_WIDTH-1:0] LAST_IDX = REG_ADDR_WIDTH'(NUM_REG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      SEND = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic [REG_ADDR_WIDTH-1:0] cur_q,   cur_d;
   logic [REG_ADDR_WIDTH-1:0] last_q,  last_d;
   logic                      valid_q, valid_d;
   logic [REG_WIDTH-1:0]      data_q,  data_d;
   logic [REG_ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic                      olast_q, olast_d;
   logic                      done_q,  done_d;
   logic                      busy_q,  busy_d;
   logic [REG_ADDR_WIDTH-1:0] cur_inc;

   // Next register index, wrapping at NUM_REG (which need not be a power of two)
   assign cur_inc = (cur_q == LAST_IDX) ? '0 : cur_q + REG_ADDR_WIDTH'(1);

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cur_q   <= '0;
         last_q  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         olast_q <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         olast_q <= olast_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state and next-output logic; abort wins over start and handshake
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      last_d  = last_q;
      valid_d = valid_q;
      data_d  = data_q;
      addr_d  = addr_q;
      olast_d = olast_q;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               cur_d   = start_addr;
               last_d  = end_addr;
               state_d = READ;
            end
         end
         READ: begin
            if (abort) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end else begin
               data_d  = rd_data;
               addr_d  = cur_q;
               olast_d = (cur_q == last_q);
               valid_d = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (abort) begin
               state_d = IDLE;
               valid_d = 1'b0;
            end else if (stream.out_ready) begin
               valid_d = 1'b0;
               if (olast_q) begin
                  state_d = DONE;
               end else begin
                  cur_d   = cur_inc;
                  state_d = READ;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            valid_d = 1'b0;
         end
      endcase

      // Status flags are registered copies of the state being entered
      done_d = (state_d == DONE);
      busy_d = (state_d != IDLE);
   end

   assign rd_addr          = cur_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign stream.out_valid = valid_q;
   assign stream.out_data  = data_q;
   assign stream.out_addr  = addr_q;
   assign stream.out_last  = olast_q;

endmodule

// File: tb/tb_reg_dump.sv
// Bench for reg_dump: fixed and randomized dumps checked against a
// queue-based model of the expected word sequence, plus abort, reset and
// start-while-busy scenarios.
module tb_reg_dump;

   localparam int unsigned NUM_REG = 32;
   localparam int unsigned AW      = 5;
   localparam int unsigned DW      = 32;
   localparam int          NR      = 32;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } word_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] end_addr;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          busy;
   logic          done;
   logic [DW-1:0] mem [NUM_REG];

   int checks = 0;
   int errors = 0;

   reg_dump_if #(.REG_ADDR_WIDTH(AW), .REG_WIDTH(DW)) stream ();

   reg_dump #(
      .NUM_REG(NUM_REG),
      .REG_ADDR_WIDTH(AW),
      .REG_WIDTH(DW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .start_addr(start_addr),
      .end_addr(end_addr),
      .rd_addr(rd_addr),
      .rd_data(rd_data),
      .abort(abort),
      .busy(busy),
      .done(done),
      .stream(stream)
   );

   always #5 clk = ~clk;

   // Register file model with a combinational read port
   assign rd_data = mem[rd_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_mem(input bit by_index);
      for (int i = 0; i < NR; i++)
         mem[i] = by_index ? DW'(i) : ($urandom | 32'h1);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b1; abort = 1'b1;
      start_addr = 5'd3; end_addr = 5'd9;
      stream.out_ready = 1'b1;
      fill_mem(1'b0);
      tick(); tick();
      start = 1'b0; abort = 1'b0;
      checks++;
      if ({stream.out_valid, stream.out_last, done, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags got valid/last/done/busy=%b want 0000",
                  {stream.out_valid, stream.out_last, done, busy});
      end
      checks++;
      if (stream.out_data !== '0 || stream.out_addr !== '0) begin
         errors++;
         $display("FAIL reset_word got data=%h addr=%0d want 0/0", stream.out_data, stream.out_addr);
      end
      checks++;
      if (rd_addr !== '0) begin
         errors++;
         $display("FAIL reset_rd_addr got %0d want 0", rd_addr);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle got busy=%b want 0", busy);
      end
   endtask

   // Table of dumps; each compared word-by-word with a model queue
   task automatic test_dumps();
      int s_tab [12] = '{1, 30, 7, 31, 0, 5, 0, 0, 0, 0, 0, 0};
      int e_tab [12] = '{5, 1, 7, 31, 31, 4, 0, 0, 0, 0, 0, 0};
      int m_tab [12] = '{0, 0, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0};
      for (int k = 6; k < 12; k++) begin
         s_tab[k] = int'($urandom_range(0, NR - 1));
         e_tab[k] = int'($urandom_range(0, NR - 1));
         m_tab[k] = int'($urandom_range(0, 1));
      end
      for (int k = 0; k < 12; k++) begin
         word_t q[$];
         int    n, cyc, last_hs, stall_cnt;
         bit    ready, prev_stall;
         fill_mem(k == 0);
         n = ((e_tab[k] - s_tab[k] + NR) % NR) + 1;
         for (int i = 0; i < n; i++) begin
            word_t w;
            w.addr = AW'((s_tab[k] + i) % NR);
            w.data = mem[(s_tab[k] + i) % NR];
            w.last = (i == n - 1);
            q.push_back(w);
         end

         start = 1'b1;
         start_addr = AW'(s_tab[k]);
         end_addr   = AW'(e_tab[k]);
         stream.out_ready = (m_tab[k] == 0);
         tick();
         start = 1'b0;
         start_addr = AW'($urandom);
         end_addr   = AW'($urandom);
         checks++;
         if (busy !== 1'b1 || stream.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump%0d_read got busy=%b valid=%b want 1/0", k, busy, stream.out_valid);
         end
         tick();
         checks++;
         if (stream.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL dump%0d_latency got valid=%b want 1", k, stream.out_valid);
         end

         cyc = 0; last_hs = -1; stall_cnt = 0; prev_stall = 1'b0;
         while (q.size() > 0 && cyc < 400) begin
            case (m_tab[k])
               0:       ready = 1'b1;
               1:       ready = 1'($urandom_range(0, 1));
               default: ready = (stall_cnt >= 3);
            endcase
            stream.out_ready = ready;
            checks++;
            if ({done, busy} !== 2'b01) begin
               errors++;
               $display("FAIL dump%0d_status cyc%0d got done/busy=%b want 01", k, cyc, {done, busy});
            end
            if (stream.out_valid === 1'b1) begin
               checks++;
               if ({stream.out_addr, stream.out_data, stream.out_last} !==
                   {q[0].addr, q[0].data, q[0].last}) begin
                  errors++;
                  $display("FAIL dump%0d_word got addr=%0d data=%h last=%b want addr=%0d data=%h last=%b",
                           k, stream.out_addr, stream.out_data, stream.out_last,
                           q[0].addr, q[0].data, q[0].last);
               end
               if (ready) begin
                  void'(q.pop_front());
                  last_hs = cyc;
               end else begin
                  stall_cnt++;
               end
               prev_stall = !ready;
            end else begin
               if (prev_stall) begin
                  checks++;
                  errors++;
                  $display("FAIL dump%0d_hold got valid=0 while stalled want 1", k);
               end
               prev_stall = 1'b0;
            end
            tick();
            cyc++;
         end
         checks++;
         if (q.size() != 0) begin
            errors++;
            $display("FAIL dump%0d_timeout got %0d words pending want 0", k, q.size());
         end
         checks++;
         if ({done, busy, stream.out_valid} !== 3'b110) begin
            errors++;
            $display("FAIL dump%0d_done got done/busy/valid=%b want 110", k, {done, busy, stream.out_valid});
         end
         tick();
         checks++;
         if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL dump%0d_idle got done/busy=%b want 00", k, {done, busy});
         end
         if (m_tab[k] == 0) begin
            checks++;
            if (last_hs != 2 * (n - 1)) begin
               errors++;
               $display("FAIL dump%0d_rate got last handshake at %0d want %0d", k, last_hs, 2 * (n - 1));
            end
         end
      end
   endtask

   task automatic test_abort();
      int  hs;
      bit  seen_done;
      fill_mem(1'b0);
      // Abort after the third accepted word of a full dump
      stream.out_ready = 1'b1;
      start = 1'b1; start_addr = 5'd0; end_addr = 5'd31;
      tick();
      start = 1'b0;
      hs = 0;
      for (int c = 0; c < 40 && hs < 3; c++) begin
         if (stream.out_valid === 1'b1) hs++;
         tick();
      end
      checks++;
      if (hs != 3) begin
         errors++;
         $display("FAIL abort_setup got %0d handshakes want 3", hs);
      end
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({stream.out_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL abort_read got valid/busy/done=%b want 000", {stream.out_valid, busy, done});
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL abort_quiet got done/busy=%b want 00", {done, busy});
         end
      end

      // Abort coinciding with the handshake of the final word
      stream.out_ready = 1'b0;
      start = 1'b1; start_addr = 5'd9; end_addr = 5'd9;
      tick();
      start = 1'b0;
      tick();
      abort = 1'b1; stream.out_ready = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if ({stream.out_valid, busy, done} !== 3'b000) begin
         errors++;
         $display("FAIL abort_send got valid/busy/done=%b want 000", {stream.out_valid, busy, done});
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL abort_nodone got done=%b want 0", done);
      end

      // Abort in IDLE overrides a simultaneous start
      abort = 1'b1; start = 1'b1; start_addr = 5'd2; end_addr = 5'd4;
      tick();
      abort = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle got busy=%b want 0", busy);
      end

      // A fresh dump after the aborts runs normally
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if ({stream.out_valid, stream.out_addr, stream.out_data} !== {1'b1, 5'd2, mem[2]}) begin
         errors++;
         $display("FAIL abort_restart got valid=%b addr=%0d data=%h want 1/2/%h",
                  stream.out_valid, stream.out_addr, stream.out_data, mem[2]);
      end
      seen_done = 1'b0;
      for (int c = 0; c < 20 && !seen_done; c++) begin
         tick();
         if (done === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (!seen_done) begin
         errors++;
         $display("FAIL abort_restart_done got no done want done pulse");
      end
      tick();
   endtask

   task automatic test_reset_mid();
      fill_mem(1'b0);
      stream.out_ready = 1'b0;
      start = 1'b1; start_addr = 5'd3; end_addr = 5'd9;
      tick();
      start = 1'b0;
      tick();
      checks++;
      if (stream.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_setup got valid=%b want 1", stream.out_valid);
      end
      rst = 1'b1; abort = 1'b1; start = 1'b1; stream.out_ready = 1'b1;
      tick();
      rst = 1'b0; abort = 1'b0; start = 1'b0;
      checks++;
      if ({stream.out_valid, stream.out_last, done, busy} !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_flags got valid/last/done/busy=%b want 0000",
                  {stream.out_valid, stream.out_last, done, busy});
      end
      checks++;
      if (stream.out_data !== '0 || stream.out_addr !== '0 || rd_addr !== '0) begin
         errors++;
         $display("FAIL rstmid_regs got data=%h addr=%0d rd_addr=%0d want 0/0/0",
                  stream.out_data, stream.out_addr, rd_addr);
      end
   endtask

   // start held high across a whole dump must not restart it
   task automatic test_start_held();
      int k;
      bit seen_done;
      fill_mem(1'b0);
      stream.out_ready = 1'b1;
      start = 1'b1; start_addr = 5'd4; end_addr = 5'd6;
      tick();
      start_addr = 5'd20; end_addr = 5'd25;
      k = 0; seen_done = 1'b0;
      for (int c = 0; c < 20 && !seen_done; c++) begin
         if (stream.out_valid === 1'b1) begin
            checks++;
            if ({stream.out_addr, stream.out_data} !== {AW'(4 + k), mem[4 + k]}) begin
               errors++;
               $display("FAIL held_word got addr=%0d data=%h want %0d/%h",
                        stream.out_addr, stream.out_data, 4 + k, mem[4 + k]);
            end
            k++;
         end
         tick();
         if (done === 1'b1) seen_done = 1'b1;
      end
      checks++;
      if (!seen_done || k != 3) begin
         errors++;
         $display("FAIL held_count got done=%b words=%0d want 1/3", seen_done, k);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL held_idle got busy=%b want 0", busy);
      end
      tick();
      checks++;
      if (busy !== 1'b1 || rd_addr !== 5'd20) begin
         errors++;
         $display("FAIL held_restart got busy=%b rd_addr=%0d want 1/20", busy, rd_addr);
      end
      start = 1'b0; abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL held_abort got busy=%b want 0", busy);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      start_addr = '0; end_addr = '0;
      stream.out_ready = 1'b0;
      test_reset();
      test_dumps();
      test_abort();
      test_reset_mid();
      test_start_held();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
